// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch/decode controller: fetches from a synchronous-read imem, decodes fields,
// hands work to the ALU/register FSM, owns the PC, and guards completion with a watchdog.
module instr_fetch_ctrl #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16,
  parameter int TIMEOUT     = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  output logic [PC_WIDTH-1:0]    imem_addr,
  output logic                   imem_rd_en,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic                   exec_start,
  input  logic                   exec_done,
  input  logic                   pc_inc,
  output logic [3:0]             opcode,
  output logic [2:0]             rd_sel,
  output logic [2:0]             rs1_sel,
  output logic [2:0]             rs2_sel,
  output logic                   busy,
  output logic                   halted,
  output logic                   timeout_err,
  output logic [15:0]            instr_count
);

  localparam int                  WD_WIDTH = $clog2(TIMEOUT + 1);
  localparam logic [WD_WIDTH-1:0] WD_LAST  = WD_WIDTH'(TIMEOUT - 1);
  localparam logic [3:0]          OP_NOP   = 4'h0;
  localparam logic [3:0]          OP_HALT  = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT_DONE,
    S_HALT
  } state_e;

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [12:0]           ir_q, ir_d;        // instr[15:3]; the low three bits carry no field
  logic [WD_WIDTH-1:0]   wd_q, wd_d;
  logic                  pc_adv_q, pc_adv_d;
  logic                  timeout_err_q, timeout_err_d;
  logic [15:0]           count_q, count_d;

  logic                  unused_imem_bits;
  logic [3:0]            ir_opcode;

  assign ir_opcode        = ir_q[12:9];
  assign unused_imem_bits = ^imem_data;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  state_d = S_LATCH;
      S_LATCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (ir_opcode == OP_HALT)     state_d = S_HALT;
        else if (ir_opcode == OP_NOP) state_d = run ? S_FETCH : S_IDLE;
        else                          state_d = S_ISSUE;
      end
      S_ISSUE:  state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (exec_done)            state_d = run ? S_FETCH : S_IDLE;
        else if (wd_q == WD_LAST) state_d = S_HALT;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath registers: PC, instruction register, watchdog, retire counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q          <= '0;
      ir_q          <= '0;
      wd_q          <= '0;
      pc_adv_q      <= 1'b0;
      timeout_err_q <= 1'b0;
      count_q       <= '0;
    end else begin
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      wd_q          <= wd_d;
      pc_adv_q      <= pc_adv_d;
      timeout_err_q <= timeout_err_d;
      count_q       <= count_d;
    end
  end

  always_comb begin
    // NOTE: every _d defaults to its _q first so no path through the case infers a latch.
    pc_d          = pc_q;
    ir_d          = ir_q;
    wd_d          = wd_q;
    pc_adv_d      = pc_adv_q;
    timeout_err_d = timeout_err_q;
    count_d       = count_q;
    case (state_q)
      S_LATCH: ir_d = imem_data[15:3];
      S_DECODE: begin
        if (ir_opcode == OP_NOP) begin
          pc_d    = pc_q + PC_WIDTH'(1);
          count_d = count_q + 16'd1;
        end
      end
      S_ISSUE: begin
        wd_d     = '0;
        pc_adv_d = 1'b0;
      end
      S_WAIT_DONE: begin
        wd_d = wd_q + WD_WIDTH'(1);
        // Retire wins over expiry; pc_inc and exec_done together still advance the PC once.
        if (exec_done) begin
          if (!pc_adv_q) pc_d = pc_q + PC_WIDTH'(1);
          count_d = count_q + 16'd1;
        end else if (wd_q == WD_LAST) begin
          timeout_err_d = 1'b1;
        end else if (pc_inc && !pc_adv_q) begin
          pc_d     = pc_q + PC_WIDTH'(1);
          pc_adv_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Outputs: decoded from the registered state or driven straight from flops
  always_comb begin
    imem_addr   = pc_q;
    imem_rd_en  = (state_q == S_FETCH);
    exec_start  = (state_q == S_ISSUE);
    busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    halted      = (state_q == S_HALT);
    timeout_err = timeout_err_q;
    instr_count = count_q;
    opcode      = ir_q[12:9];
    rd_sel      = ir_q[8:6];
    rs1_sel     = ir_q[5:3];
    rs2_sel     = ir_q[2:0];
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: a program-walk reference model fills fetch/issue scoreboards
// that a negedge monitor drains, plus directed timing, wrap, watchdog and interruption cases.
module tb_instr_fetch_ctrl;
  localparam int PW = 8;
  localparam int IW = 16;
  localparam int TO = 32;
  localparam int W_FETCH = 0;
  localparam int W_START = 1;
  localparam int W_HALT  = 2;

  logic          clk = 1'b0;
  logic          reset, run, exec_done, pc_inc;
  logic [PW-1:0] imem_addr;
  logic          imem_rd_en, exec_start, busy, halted, timeout_err;
  logic [IW-1:0] imem_data;
  logic [3:0]    opcode;
  logic [2:0]    rd_sel, rs1_sel, rs2_sel;
  logic [15:0]   instr_count;

  always #5 clk = ~clk;

  instr_fetch_ctrl #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .run(run),
    .imem_addr(imem_addr), .imem_rd_en(imem_rd_en), .imem_data(imem_data),
    .exec_start(exec_start), .exec_done(exec_done), .pc_inc(pc_inc),
    .opcode(opcode), .rd_sel(rd_sel), .rs1_sel(rs1_sel), .rs2_sel(rs2_sel),
    .busy(busy), .halted(halted), .timeout_err(timeout_err), .instr_count(instr_count)
  );

  typedef struct {
    logic [7:0] addr;
    logic [3:0] op;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
  } issue_t;

  typedef struct {
    int dly;
    int p1;
    int p2;
  } resp_t;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         start_cnt = 0;
  logic [15:0] mem [256];
  logic [7:0] fetch_q [$];
  issue_t     issue_q [$];
  resp_t      resp_q [$];
  issue_t     mon_e;
  resp_t      rsp;
  bit         mon_en = 1'b1;
  bit         resp_en = 1'b1;
  bit         noise_en = 1'b0;
  bit         rand_run = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read instruction memory
  always @(posedge clk) if (imem_rd_en) imem_data <= mem[imem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic bit sig_sel(input int which);
    case (which)
      W_FETCH: return imem_rd_en === 1'b1;
      W_START: return exec_start === 1'b1;
      default: return halted === 1'b1;
    endcase
  endfunction

  task automatic wait_for(input string name, input int which, input int bound);
    int n;
    n = 0;
    while (!sig_sel(which) && n < bound) begin
      step(1);
      n++;
    end
    if (!sig_sel(which)) begin
      checks++;
      failures++;
      $display("FAIL %s_wait actual=absent_after_%0d_cycles expected=present", name, bound);
    end
  endtask

  task automatic check_zero(input string name);
    check({name, "_ctl"}, {imem_addr, imem_rd_en, exec_start, busy, halted, timeout_err}, 0);
    check({name, "_fields"}, {opcode, rd_sel, rs1_sel, rs2_sel}, 0);
    check({name, "_count"}, instr_count, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    run   = 1'b0;
    step(2);
    check_zero("reset");
    fetch_q.delete();
    issue_q.delete();
    resp_q.delete();
    start_cnt = 0;
    reset = 1'b1;
  endtask

  task automatic fill_mem(input logic [15:0] w);
    for (int i = 0; i < 256; i++) mem[i] = w;
  endtask

  // Reference model: walk the program from PC 0 until HALT. Every fetched address is
  // expected in order; every non-NOP op is expected to issue; each retire adds 1 to PC.
  task automatic build_expect(output int exp_count, output int exp_pc);
    int pc;
    int cnt;
    logic [15:0] w;
    pc = 0;
    cnt = 0;
    for (int n = 0; n < 1000; n++) begin
      w = mem[pc];
      fetch_q.push_back(8'(pc));
      if (w[15:12] == 4'hF) break;
      if (w[15:12] != 4'h0)
        issue_q.push_back('{addr: 8'(pc), op: w[15:12], rd: w[11:9], rs1: w[8:6], rs2: w[5:3]});
      cnt = (cnt + 1) % 65536;
      pc  = (pc + 1) % 256;
    end
    exp_count = cnt;
    exp_pc    = pc;
  endtask

  // Monitor: pops the scoreboards whenever the DUT fetches or issues
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (exec_start === 1'b1) start_cnt++;
      if (mon_en && imem_rd_en === 1'b1) begin
        if (fetch_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL fetch_unexpected actual=%0h expected=none", imem_addr);
        end else begin
          check("fetch_addr", imem_addr, fetch_q.pop_front());
        end
      end
      if (mon_en && exec_start === 1'b1) begin
        if (issue_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL issue_unexpected actual=%0h expected=none", imem_addr);
        end else begin
          mon_e = issue_q.pop_front();
          check("issue_addr", imem_addr, mon_e.addr);
          check("issue_fields", {opcode, rd_sel, rs1_sel, rs2_sel},
                {mon_e.op, mon_e.rd, mon_e.rs1, mon_e.rs2});
        end
      end
    end
  end

  // ALU/register FSM stand-in: pc_inc pulses at p1/p2 and exec_done at dly cycles after exec_start
  initial begin
    exec_done = 1'b0;
    pc_inc    = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      pc_inc    = noise_en && ($urandom_range(0, 3) == 0);
      exec_done = noise_en && ($urandom_range(0, 3) == 0);
      if (exec_start === 1'b1 && resp_en) begin
        if (resp_q.size() > 0) begin
          rsp = resp_q.pop_front();
        end else begin
          rsp.dly = $urandom_range(1, 6);
          rsp.p1  = $urandom_range(0, rsp.dly);
          rsp.p2  = $urandom_range(0, rsp.dly);
        end
        for (int k = 1; k <= rsp.dly; k++) begin
          @(posedge clk);
          #1;
          pc_inc    = (k == rsp.p1) || (k == rsp.p2);
          exec_done = (k == rsp.dly);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_run) run = ($urandom_range(0, 5) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int f, s, ec, ep, len;
    logic [3:0] op;
    reset = 1'b0;
    run   = 1'b0;

    // Single op with pc_inc at S+6 and exec_done at S+7
    fill_mem(16'hF000);
    mem[0] = 16'h1A48;
    do_reset();
    build_expect(ec, ep);
    resp_q.push_back('{dly: 7, p1: 6, p2: 0});
    run = 1'b1;
    wait_for("t1_fetch", W_FETCH, 10);
    f = cyc;
    check("t1_fetch_addr", imem_addr, 0);
    wait_for("t1_start", W_START, 10);
    s = cyc;
    check("t1_issue_latency", s - f, 3);
    check("t1_fields", {opcode, rd_sel, rs1_sel, rs2_sel}, {4'd1, 3'd5, 3'd1, 3'd1});
    step(6);
    check("t1_pc_during_pcinc", imem_addr, 0);
    step(1);
    check("t1_pc_after_pcinc", imem_addr, 1);
    check("t1_count_before_retire", instr_count, 0);
    step(1);
    check("t1_count_after_retire", instr_count, 1);
    check("t1_refetch", {imem_rd_en, imem_addr}, {1'b1, 8'd1});
    wait_for("t1_halt", W_HALT, 20);
    check("t1_start_pulses", start_cnt, 1);
    check("t1_sb_drain", fetch_q.size() + issue_q.size(), 0);

    // NOP, NOP, HALT
    fill_mem(16'hF000);
    mem[0] = 16'h0000;
    mem[1] = 16'h0123;
    do_reset();
    build_expect(ec, ep);
    run = 1'b1;
    wait_for("t2_fetch", W_FETCH, 10);
    f = cyc;
    wait_for("t2_halt", W_HALT, 40);
    check("t2_halt_cycle", cyc - f, 9);
    check("t2_pc", imem_addr, 2);
    check("t2_count", instr_count, 2);
    check("t2_start_pulses", start_cnt, 0);
    run = 1'b0;
    step(2);
    run = 1'b1;
    step(3);
    check("t2_halt_sticky", {halted, busy, imem_rd_en}, 3'b100);
    check("t2_sb_drain", fetch_q.size() + issue_q.size(), 0);

    // PC wrap: 255 NOPs, an op at 8'hFF, then HALT at 0 on the second pass
    mon_en = 1'b0;
    fill_mem(16'h0000);
    mem[255] = 16'h2000 | 16'($urandom_range(0, 4095));
    do_reset();
    resp_q.push_back('{dly: 2, p1: 1, p2: 0});
    run = 1'b1;
    wait_for("t3_start", W_START, 900);
    check("t3_issue_addr", imem_addr, 8'hFF);
    mem[0] = 16'hF000;
    wait_for("t3_halt", W_HALT, 30);
    check("t3_pc_wrapped", imem_addr, 0);
    check("t3_count", instr_count, 256);
    mon_en = 1'b1;

    // exec_done without pc_inc, then two pc_inc pulses in one instruction
    fill_mem(16'hF000);
    mem[0] = 16'h3249;
    mem[1] = 16'h4B6D;
    do_reset();
    build_expect(ec, ep);
    resp_q.push_back('{dly: 3, p1: 0, p2: 0});
    resp_q.push_back('{dly: 4, p1: 1, p2: 3});
    run = 1'b1;
    wait_for("t4_start0", W_START, 10);
    step(3);
    check("t4_pc_before_done", imem_addr, 0);
    step(1);
    check("t4_pc_done_only", imem_addr, 1);
    wait_for("t4_start1", W_START, 10);
    step(2);
    check("t4_pc_first_pcinc", imem_addr, 2);
    step(3);
    check("t4_pc_double_pcinc", imem_addr, 2);
    wait_for("t4_halt", W_HALT, 20);
    check("t4_count", instr_count, ec);
    check("t4_pc_final", imem_addr, ep);
    check("t4_sb_drain", fetch_q.size() + issue_q.size(), 0);

    // Watchdog: exec_done withheld
    mon_en  = 1'b0;
    resp_en = 1'b0;
    fill_mem(16'hF000);
    mem[0] = 16'h5C3A;
    do_reset();
    run = 1'b1;
    wait_for("t5_start", W_START, 10);
    step(TO);
    check("t5_before_expiry", {timeout_err, halted}, 2'b00);
    step(1);
    check("t5_expiry", {timeout_err, halted}, 2'b11);
    check("t5_pc_unchanged", imem_addr, 0);
    check("t5_count", {busy, instr_count}, 0);
    step(3);
    check("t5_sticky", {timeout_err, halted}, 2'b11);
    do_reset();
    resp_en = 1'b1;
    mon_en  = 1'b1;

    // run dropped during WAIT_DONE
    fill_mem(16'hF000);
    mem[0] = 16'h6A5A;
    do_reset();
    build_expect(ec, ep);
    resp_q.push_back('{dly: 5, p1: 2, p2: 0});
    run = 1'b1;
    wait_for("t6_start", W_START, 10);
    step(1);
    run = 1'b0;
    step(5);
    check("t6_idle_after_retire", {busy, imem_rd_en, halted}, 3'b000);
    check("t6_pc", imem_addr, 1);
    check("t6_count", instr_count, 1);
    step(3);
    check("t6_stays_idle", {busy, imem_rd_en}, 2'b00);
    run = 1'b1;
    wait_for("t6_halt", W_HALT, 20);
    check("t6_sb_drain", fetch_q.size() + issue_q.size(), 0);

    // Reset asserted during WAIT_DONE; the late exec_done lands in IDLE
    mon_en = 1'b0;
    fill_mem(16'hF000);
    mem[0] = 16'h7123;
    do_reset();
    resp_q.push_back('{dly: 10, p1: 0, p2: 0});
    run = 1'b1;
    wait_for("t7_start", W_START, 10);
    step(3);
    check("t7_busy_in_wait", busy, 1);
    reset = 1'b0;
    run   = 1'b0;
    step(1);
    check_zero("t7_mid_reset");
    reset = 1'b1;
    step(12);
    check("t7_late_done_ignored", {busy, imem_addr, instr_count}, 0);
    mon_en = 1'b1;

    // Randomized programs with random handshakes, stray strobes and run toggling
    for (int p = 0; p < 6; p++) begin
      fill_mem(16'hF000);
      len = $urandom_range(8, 40);
      for (int i = 0; i < len; i++) begin
        op = 4'($urandom_range(0, 14));
        if ($urandom_range(0, 3) == 0) op = 4'h0;
        mem[i] = {op, 12'($urandom_range(0, 4095))};
      end
      do_reset();
      build_expect(ec, ep);
      noise_en = 1'b1;
      rand_run = 1'b1;
      run      = 1'b1;
      wait_for("rnd_halt", W_HALT, 4000);
      noise_en = 1'b0;
      rand_run = 1'b0;
      run      = 1'b0;
      check("rnd_pc", imem_addr, ep);
      check("rnd_count", instr_count, ec);
      check("rnd_sb_drain", fetch_q.size() + issue_q.size(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
